// File: rtl/gemm_result_streamer_pkg.sv
// Shared types and index-width helpers for the GEMM result streaming path.
package gemm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } gemm_strm_state_t;

  // Index width for a dimension of n entries; a 1-entry dimension still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_MATRIX_HEIGHT = 4;
  localparam int DEF_MATRIX_WIDTH  = 4;
  localparam int ROW_IDX_W         = idx_w(DEF_MATRIX_HEIGHT);
  localparam int COL_IDX_W         = idx_w(DEF_MATRIX_WIDTH);

endpackage

// File: rtl/gemm_result_streamer_if.sv
// Element stream from the result streamer toward the writeback/host path.
interface gemm_result_streamer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ROW_W      = 2,
  parameter int COL_W      = 2
);
  logic                  ovalid;
  logic                  iready;
  logic [DATA_WIDTH-1:0] odata;
  logic [ROW_W-1:0]      orow;
  logic [COL_W-1:0]      ocol;
  logic                  olast;

  modport master (output ovalid, odata, orow, ocol, olast, input iready);
  modport slave  (input ovalid, odata, orow, ocol, olast, output iready);
endinterface

// File: rtl/gemm_result_streamer_idx_counter.sv
// Row-major 2-D index counter: column is the inner index and wraps into the row.
module gemm_idx_counter
  import gemm_pkg::*;
#(
  parameter int HEIGHT = 4,
  parameter int WIDTH  = 4,
  parameter int RW     = idx_w(HEIGHT),
  parameter int CW     = idx_w(WIDTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          at_last_o
);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          row_last_s;
  logic          col_last_s;

  assign row_last_s = (row_q == RW'(HEIGHT - 1));
  assign col_last_s = (col_q == CW'(WIDTH - 1));

  // Next index: clear wins over advance; the last element wraps back to (0,0).
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_last_s) begin
        col_d = '0;
        row_d = row_last_s ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Index registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o     = row_q;
  assign col_o     = col_q;
  assign at_last_o = row_last_s && col_last_s;

endmodule

// File: rtl/gemm_result_streamer.sv
// Snapshots the GEMM result matrix on istart and drains it row-major over a valid/ready stream.
// Optional stall counter enabled by GEMM_STREAM_STALL_CNT_EN.
module gemm_result_streamer
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int MATRIX_WIDTH  = 4,
  parameter int MATRIX_HEIGHT = 4
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  istart,
  input  logic [DATA_WIDTH-1:0] result_matrix [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1],
  output logic                  obusy,
  output logic                  odone,
  output logic [31:0]           ostall_cnt,
  gemm_result_streamer_if.master strm
);

  localparam int RW = idx_w(MATRIX_HEIGHT);
  localparam int CW = idx_w(MATRIX_WIDTH);

  gemm_strm_state_t      state_q, state_d;
  logic                  valid_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] snap_q [0:MATRIX_HEIGHT-1][0:MATRIX_WIDTH-1];
  logic                  capture_s;
  logic                  advance_s;
  logic                  hs_s;
  logic                  at_last_s;
  logic [RW-1:0]         row_s;
  logic [CW-1:0]         col_s;

  assign hs_s = valid_q && strm.iready;

  gemm_idx_counter #(
    .HEIGHT (MATRIX_HEIGHT),
    .WIDTH  (MATRIX_WIDTH),
    .RW     (RW),
    .CW     (CW)
  ) u_idx (
    .clk_i     (iclk),
    .rst_i     (irst),
    .clear_i   (capture_s),
    .advance_i (advance_s),
    .row_o     (row_s),
    .col_o     (col_s),
    .at_last_o (at_last_s)
  );

  // Next state and per-cycle controls; istart only matters in IDLE.
  always_comb begin
    state_d   = state_q;
    capture_s = 1'b0;
    advance_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (istart) begin
          state_d   = STREAM;
          capture_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (hs_s) begin
          advance_s = 1'b1;
          state_d   = at_last_s ? DONE : STREAM;
        end else begin
          state_d = STREAM;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered status outputs.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == STREAM);
      done_q  <= (state_d == DONE);
    end
  end

  // Snapshot lets the GEMM core keep overwriting its results during the drain.
  always_ff @(posedge iclk) begin
    for (int r = 0; r < MATRIX_HEIGHT; r++) begin
      for (int c = 0; c < MATRIX_WIDTH; c++) begin
        if (irst) begin
          snap_q[r][c] <= '0;
        end else if (capture_s) begin
          snap_q[r][c] <= result_matrix[r][c];
        end
      end
    end
  end

`ifdef GEMM_STREAM_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of stalled cycles for the most recent capture.
  always_ff @(posedge iclk) begin
    if (irst) begin
      stall_q <= 32'd0;
    end else if (capture_s) begin
      stall_q <= 32'd0;
    end else if (valid_q && !strm.iready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign ostall_cnt = stall_q;
`else
  assign ostall_cnt = 32'd0;
`endif

  assign obusy       = valid_q;
  assign odone       = done_q;
  assign strm.ovalid = valid_q;
  assign strm.odata  = valid_q ? snap_q[row_s][col_s] : '0;
  assign strm.orow   = row_s;
  assign strm.ocol   = col_s;
  assign strm.olast  = valid_q && at_last_s;

endmodule

// File: tb/tb_gemm_result_streamer.sv
// Directed bench for gemm_result_streamer: reset, full-rate, backpressure, isolation, busy start, mid-stream reset.
module tb_gemm_result_streamer;

  logic        iclk;
  logic        irst;
  logic        istart;
  logic [63:0] rm [0:3][0:3];
  logic        obusy;
  logic        odone;
  logic [31:0] ostall_cnt;
  int          n_cmp;
  int          n_err;

  gemm_result_streamer_if #(.DATA_WIDTH(64), .ROW_W(2), .COL_W(2)) strm_if ();

  gemm_result_streamer #(
    .DATA_WIDTH    (64),
    .MATRIX_WIDTH  (4),
    .MATRIX_HEIGHT (4)
  ) dut (
    .iclk          (iclk),
    .irst          (irst),
    .istart        (istart),
    .result_matrix (rm),
    .obusy         (obusy),
    .odone         (odone),
    .ostall_cnt    (ostall_cnt),
    .strm          (strm_if.master)
  );

  always #5 iclk = ~iclk;

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input bit dead);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        rm[i][j] = dead ? 64'hDEAD : (64'h100 * 64'(i) + 64'(j));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(strm_if.ovalid), 64'd0);
    chk({tag, "_busy"},  64'(obusy),          64'd0);
    chk({tag, "_done"},  64'(odone),          64'd0);
    chk({tag, "_data"},  strm_if.odata,       64'd0);
    chk({tag, "_last"},  64'(strm_if.olast),  64'd0);
  endtask

  // pat 0: iready always 1; pat 1: iready = 1,0,0,1,0,0,...
  task automatic run(input string nm, input int pat, input bit dead, input bit busy_start,
                     input int rst_at, input int exp_done, input int exp_stall);
    int k;
    int cyc;
    bit fin;
    bit was_rst;
    k = 0; cyc = 0; fin = 0; was_rst = 0;
    istart = 1'b1;
    tick();
    istart = 1'b0;
    while (!fin && cyc < 300) begin
      strm_if.iready = (pat == 0) ? 1'b1 : (cyc % 3 == 0);
      if (dead && cyc == 0) fill(1'b1);
      if (rst_at != 0 && k == rst_at) begin
        irst = 1'b1;
        tick();
        chk({nm, "_rst_valid"}, 64'(strm_if.ovalid), 64'd0);
        chk({nm, "_rst_busy"},  64'(obusy),          64'd0);
        chk({nm, "_rst_done"},  64'(odone),          64'd0);
        irst = 1'b0;
        tick();
        chk({nm, "_post_rst_done"},  64'(odone),          64'd0);
        chk({nm, "_post_rst_valid"}, 64'(strm_if.ovalid), 64'd0);
        fin = 1'b1;
        was_rst = 1'b1;
      end else begin
        if (k < 16) begin
          istart = busy_start && (k == 5);
          chk({nm, "_valid"}, 64'(strm_if.ovalid), 64'd1);
          chk({nm, "_busy"},  64'(obusy),          64'd1);
          chk({nm, "_done0"}, 64'(odone),          64'd0);
          chk({nm, "_data"},  strm_if.odata,       64'h100 * 64'(k / 4) + 64'(k % 4));
          chk({nm, "_row"},   64'(strm_if.orow),   64'(k / 4));
          chk({nm, "_col"},   64'(strm_if.ocol),   64'(k % 4));
          chk({nm, "_last"},  64'(strm_if.olast),  64'(k == 15));
          if (strm_if.iready) k++;
        end else begin
          chk({nm, "_done"},      64'(odone),          64'd1);
          chk({nm, "_done_vld"},  64'(strm_if.ovalid), 64'd0);
          chk({nm, "_done_busy"}, 64'(obusy),          64'd0);
          chk({nm, "_done_cyc"},  64'(cyc),            64'(exp_done));
          istart = busy_start;
          fin = 1'b1;
        end
        tick();
        cyc++;
      end
    end
    istart = 1'b0;
    if (!fin) chk({nm, "_timeout"}, 64'd0, 64'd1);
    if (!was_rst) begin
      chk({nm, "_after_done"},  64'(odone),          64'd0);
      chk({nm, "_after_valid"}, 64'(strm_if.ovalid), 64'd0);
`ifdef GEMM_STREAM_STALL_CNT_EN
      chk({nm, "_stall_cnt"}, 64'(ostall_cnt), 64'(exp_stall));
`else
      chk({nm, "_stall_cnt"}, 64'(ostall_cnt), 64'(exp_stall * 0));
`endif
      tick();
      chk({nm, "_idle_valid"}, 64'(strm_if.ovalid), 64'd0);
      chk({nm, "_idle_done"},  64'(odone),          64'd0);
    end
    if (dead) fill(1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    iclk = 1'b0;
    irst = 1'b1;
    istart = 1'b0;
    strm_if.iready = 1'b0;
    fill(1'b0);
    repeat (3) tick();
    chk_idle("in_reset");
    irst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("idle");
      chk("idle_stall", 64'(ostall_cnt), 64'd0);
    end

    run("full",      0, 1'b0, 1'b0, 0, 16,  0);
    run("bp",        1, 1'b0, 1'b0, 0, 46, 30);
    run("isolate",   0, 1'b1, 1'b0, 0, 16,  0);
    run("busy",      0, 1'b0, 1'b1, 0, 16,  0);
    run("midrst",    0, 1'b0, 1'b0, 7,  0,  0);
    run("after_rst", 0, 1'b0, 1'b0, 0, 16,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
